// File: rtl/auth_login_control.sv
// Login authorizer: selects a user ID, checks a PASS_LEN-digit password digit by digit
// against the password RAM, issues a one-cycle login pulse and enforces a fail lockout.
module auth_login_control #(
  parameter int unsigned PASS_LEN    = 6,
  parameter int unsigned NUM_USERS   = 10,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned MAX_FAILS   = 3,
  parameter int unsigned LOCK_CYCLES = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Button1_Wire,
  input  logic       Button3_Wire,
  input  logic [3:0] digitInput,
  input  logic       logOutSignalInput,
  input  logic [3:0] ramPassData,
  output logic [5:0] ramPassAddress,
  output logic [5:0] passBeginAddress,
  output logic       loggedInSignalOutput,
  output logic [2:0] authState,
  output logic [2:0] digitCount,
  output logic       failLED,
  output logic       lockLED
);

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned LOCK_W  = 26;
  localparam int unsigned WAIT_W  = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_GET_DIGIT   = 3'd1,
    S_READ_WAIT   = 3'd2,
    S_COMPARE     = 3'd3,
    S_LOGIN_PULSE = 3'd4,
    S_LOGGED_IN   = 3'd5,
    S_FAIL        = 3'd6,
    S_LOCKED      = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                mismatch_q, mismatch_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [FAIL_W-1:0]   fail_inc;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    dcnt_q, dcnt_d;
  logic                login_q, login_d;
  logic                fail_led_q, fail_led_d;
  logic                lock_led_q, lock_led_d;

  assign fail_inc = fail_cnt_q + FAIL_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    mismatch_d = mismatch_q;
    wait_d     = wait_q;
    fail_cnt_d = fail_cnt_q;
    lock_cnt_d = lock_cnt_q;
    base_d     = base_q;
    addr_d     = addr_q;
    dcnt_d     = dcnt_q;
    fail_led_d = fail_led_q;
    login_d    = 1'b0;
    lock_led_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (Button1_Wire && (32'(digitInput) < NUM_USERS)) begin
          base_d     = ADDR_W'(32'(digitInput) * PASS_LEN);
          dcnt_d     = '0;
          mismatch_d = 1'b0;
          fail_led_d = 1'b0;
          state_d    = S_GET_DIGIT;
        end
      end
      S_GET_DIGIT: begin
        if (Button3_Wire) begin
          state_d = S_IDLE;
        end else if (Button1_Wire) begin
          digit_d = digitInput;
          addr_d  = base_q + ADDR_W'(dcnt_q);
          wait_d  = '0;
          state_d = S_READ_WAIT;
        end
      end
      S_READ_WAIT: begin
        if (wait_q == WAIT_W'(RAM_LATENCY - 1)) begin
          state_d = S_COMPARE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_COMPARE: begin
        // Mismatch is sticky so the user never learns which digit was wrong
        mismatch_d = mismatch_q | (digit_q != ramPassData);
        dcnt_d     = dcnt_q + CNT_W'(1);
        if (dcnt_q == CNT_W'(PASS_LEN - 1)) begin
          if (mismatch_d) begin
            fail_led_d = 1'b1;
            state_d    = S_FAIL;
          end else begin
            state_d = S_LOGIN_PULSE;
          end
        end else begin
          state_d = S_GET_DIGIT;
        end
      end
      S_LOGIN_PULSE: begin
        fail_cnt_d = '0;
        state_d    = S_LOGGED_IN;
      end
      S_LOGGED_IN: begin
        if (logOutSignalInput) begin
          base_d     = '0;
          dcnt_d     = '0;
          fail_led_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_FAIL: begin
        fail_led_d = 1'b1;
        if (fail_inc == FAIL_W'(MAX_FAILS)) begin
          fail_cnt_d = '0;
          lock_cnt_d = LOCK_W'(LOCK_CYCLES - 1);
          state_d    = S_LOCKED;
        end else begin
          fail_cnt_d = fail_inc;
          state_d    = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (lock_cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LOCK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pulse and lock indicators follow the state being entered so they are registered
    login_d    = (state_d == S_LOGIN_PULSE);
    lock_led_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      digit_q    <= '0;
      mismatch_q <= 1'b0;
      wait_q     <= '0;
      fail_cnt_q <= '0;
      lock_cnt_q <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      dcnt_q     <= '0;
      login_q    <= 1'b0;
      fail_led_q <= 1'b0;
      lock_led_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digit_q    <= digit_d;
      mismatch_q <= mismatch_d;
      wait_q     <= wait_d;
      fail_cnt_q <= fail_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      dcnt_q     <= dcnt_d;
      login_q    <= login_d;
      fail_led_q <= fail_led_d;
      lock_led_q <= lock_led_d;
    end
  end

  assign authState            = state_q;
  assign ramPassAddress       = addr_q;
  assign passBeginAddress     = base_q;
  assign digitCount           = dcnt_q;
  assign loggedInSignalOutput = login_q;
  assign failLED              = fail_led_q;
  assign lockLED              = lock_led_q;

endmodule
